mem_wb_pipe: RTL and testbench

- Parametrised successor to the fixed MEM/WB stage register.
- Carries load data, ALU result, rd index and writeback controls from MEM to WB.
- Adds a valid/ready handshake, an optional 2-entry skid buffer, synchronous flush, writeback-data selection and a retire counter.
- Sits between the MEM stage and the register-file write port. Lets WB back-pressure MEM without a combinational ready path.

---
 rtl/mem_wb_pipe.sv | 169 ++++++++++++++++
 tb/tb_mem_wb_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe.sv
// MEM/WB stage register: valid/ready handshake, optional skid entry, synchronous
// flush, writeback-data select, x0 write suppression and a wrapping retire counter.
module mem_wb_pipe #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int SKID        = 1,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_m_data,
  input  logic [XLEN-1:0]        in_ex_result,
  input  logic                   in_reg_write,
  input  logic                   in_memtoreg,
  input  logic [RFIDX_WIDTH-1:0] in_rd_index,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_wb_data,
  output logic                   out_reg_write,
  output logic [RFIDX_WIDTH-1:0] out_rd_index,
  output logic [CNT_W-1:0]       retire_count
);

  typedef struct packed {
    logic [XLEN-1:0]        m_data;
    logic [XLEN-1:0]        ex_result;
    logic                   reg_write;
    logic                   memtoreg;
    logic [RFIDX_WIDTH-1:0] rd;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  entry_t           r_main;
  entry_t           r_skid;
  entry_t           w_in_entry;
  logic             r_in_ready;
  logic             w_in_ready_nxt;
  logic [CNT_W-1:0] r_retire_count;
  logic             w_out_valid;
  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_load_main_in;
  logic             w_load_main_skid;
  logic             w_load_skid;

  // Handshake qualification; without a skid entry ready must look through to out_ready.
  always_comb begin
    w_in_entry.m_data    = in_m_data;
    w_in_entry.ex_result = in_ex_result;
    w_in_entry.reg_write = in_reg_write;
    w_in_entry.memtoreg  = in_memtoreg;
    w_in_entry.rd        = in_rd_index;
    w_out_valid          = (r_state != ST_EMPTY);
    w_out_fire           = w_out_valid & out_ready;
    if (SKID != 0) begin
      w_in_ready = r_in_ready;
    end else begin
      w_in_ready = ~w_out_valid | out_ready;
    end
    w_in_fire = in_valid & w_in_ready;
  end

  // Next-state and load-select decode; flush overrides every transition.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt    = ST_ONE;
          w_load_main_in = 1'b1;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_state_nxt    = ST_ONE;
          w_load_main_in = 1'b1;
        end else if (w_in_fire) begin
          if (SKID != 0) begin
            w_state_nxt = ST_TWO;
            w_load_skid = 1'b1;
          end else begin
            w_state_nxt    = ST_ONE;
            w_load_main_in = 1'b1;
          end
        end else if (w_out_fire) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_ONE;
        end
      end
      ST_TWO: begin
        if (w_out_fire) begin
          w_state_nxt      = ST_ONE;
          w_load_main_skid = 1'b1;
        end else begin
          w_state_nxt = ST_TWO;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
    if (flush) begin
      w_state_nxt      = ST_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end else begin
      w_state_nxt = w_state_nxt;
    end
    w_in_ready_nxt = (w_state_nxt != ST_TWO);
  end

  // State, registered ready and retire counter; the counter survives flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_EMPTY;
      r_in_ready     <= 1'b1;
      r_retire_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= w_in_ready_nxt;
      if (w_out_fire) begin
        r_retire_count <= r_retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Entry storage; fields only ever load from a fired input or the skid entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main <= w_in_entry;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_in_entry;
      end
    end
  end

  assign in_ready      = w_in_ready;
  assign out_valid     = w_out_valid;
  assign out_wb_data   = r_main.memtoreg ? r_main.m_data : r_main.ex_result;
  assign out_reg_write = w_out_valid & r_main.reg_write & (r_main.rd != '0);
  assign out_rd_index  = r_main.rd;
  assign retire_count  = r_retire_count;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: three instances (skid, no skid, 4-bit counter) checked every
// cycle against a queue model, plus directed literal expectations.
module tb_mem_wb_pipe;
  localparam int XL = 32;
  localparam int RW = 5;

  typedef struct packed {
    logic [XL-1:0] m;
    logic [XL-1:0] ex;
    logic          rw;
    logic          mtr;
    logic [RW-1:0] rd;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, out_ready;
  logic          iv[3], irw[3], imtr[3];
  logic [XL-1:0] im[3], iex[3];
  logic [RW-1:0] ird[3];
  logic          ir[3], ov[3], orw[3];
  logic [XL-1:0] owb[3];
  logic [RW-1:0] ord[3];
  logic [31:0]   cnt0, cnt1;
  logic [3:0]    cnt2;

  mem_wb_pipe #(.XLEN(XL), .RFIDX_WIDTH(RW), .SKID(1), .CNT_W(32)) u_s (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_m_data(im[0]), .in_ex_result(iex[0]), .in_reg_write(irw[0]), .in_memtoreg(imtr[0]),
    .in_rd_index(ird[0]), .out_valid(ov[0]), .out_ready(out_ready), .out_wb_data(owb[0]),
    .out_reg_write(orw[0]), .out_rd_index(ord[0]), .retire_count(cnt0));

  mem_wb_pipe #(.XLEN(XL), .RFIDX_WIDTH(RW), .SKID(0), .CNT_W(32)) u_n (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_m_data(im[1]), .in_ex_result(iex[1]), .in_reg_write(irw[1]), .in_memtoreg(imtr[1]),
    .in_rd_index(ird[1]), .out_valid(ov[1]), .out_ready(out_ready), .out_wb_data(owb[1]),
    .out_reg_write(orw[1]), .out_rd_index(ord[1]), .retire_count(cnt1));

  mem_wb_pipe #(.XLEN(XL), .RFIDX_WIDTH(RW), .SKID(1), .CNT_W(4)) u_w (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_m_data(im[2]), .in_ex_result(iex[2]), .in_reg_write(irw[2]), .in_memtoreg(imtr[2]),
    .in_rd_index(ird[2]), .out_valid(ov[2]), .out_ready(out_ready), .out_wb_data(owb[2]),
    .out_reg_write(orw[2]), .out_rd_index(ord[2]), .retire_count(cnt2));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit src_en = 1'b0;
  ent_t src[$];
  int idx[3];
  ent_t mq[3][0:1];
  int msz[3];
  int unsigned mcnt[3];

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d actual=%h expected=%h at %0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [XL-1:0] m, input logic [XL-1:0] ex,
                              input logic rwv, input logic mtr, input logic [RW-1:0] rd);
    ent_t e;
    e.m = m; e.ex = ex; e.rw = rwv; e.mtr = mtr; e.rd = rd;
    return e;
  endfunction

  function automatic logic [63:0] dut_cnt(input int k);
    if (k == 0) return 64'(cnt0);
    else if (k == 1) return 64'(cnt1);
    else return 64'(cnt2);
  endfunction

  function automatic bit model_ready(input int k);
    if (k == 1) return (msz[k] == 0) || out_ready;
    else return msz[k] < 2;
  endfunction

  // Offer the next source entry per instance, or junk with in_valid low.
  task automatic drive();
    for (int k = 0; k < 3; k++) begin
      if (src_en && idx[k] < src.size()) begin
        iv[k] = 1'b1;
        im[k] = src[idx[k]].m; iex[k] = src[idx[k]].ex; irw[k] = src[idx[k]].rw;
        imtr[k] = src[idx[k]].mtr; ird[k] = src[idx[k]].rd;
      end else begin
        iv[k] = 1'b0;
        im[k] = $urandom; iex[k] = $urandom; irw[k] = 1'($urandom_range(0, 1));
        imtr[k] = 1'($urandom_range(0, 1)); ird[k] = RW'($urandom_range(0, 31));
      end
    end
  endtask

  // Behavioural FIFO model: capacity 2 with skid, capacity 1 (pass-through ready) without.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      bit fo, fi;
      fo = (msz[k] > 0) && out_ready;
      fi = iv[k] && model_ready(k);
      if (rst) begin
        msz[k] = 0;
        mcnt[k] = 0;
      end else begin
        if (fo) mcnt[k] = (k == 2) ? (mcnt[k] + 1) % 16 : mcnt[k] + 1;
        if (fi) idx[k]++;
        if (flush) begin
          msz[k] = 0;
        end else begin
          if (fo) begin
            mq[k][0] = mq[k][1];
            msz[k]--;
          end
          if (fi) begin
            mq[k][msz[k]] = mk(im[k], iex[k], irw[k], imtr[k], ird[k]);
            msz[k]++;
          end
        end
      end
    end
  endtask

  task automatic step();
    drive();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic new_src();
    src.delete();
    for (int k = 0; k < 3; k++) idx[k] = 0;
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        ent_t h;
        h = mq[k][0];
        chk("in_ready", k, 64'(ir[k]), 64'(model_ready(k)));
        chk("out_valid", k, 64'(ov[k]), 64'(msz[k] > 0));
        if (msz[k] > 0) begin
          chk("wb_data", k, 64'(owb[k]), 64'(h.mtr ? h.m : h.ex));
          chk("rd_index", k, 64'(ord[k]), 64'(h.rd));
          chk("reg_write", k, 64'(orw[k]), 64'(h.rw && (h.rd != 5'd0)));
        end else begin
          chk("reg_write_idle", k, 64'(orw[k]), 64'd0);
        end
        chk("retire_count", k, dut_cnt(k), 64'(mcnt[k]));
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin idx[k] = 0; msz[k] = 0; mcnt[k] = 0; end
    step();
    step();
    chk_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", k, 64'(ov[k]), 64'd0);
      chk("rst_wb", k, 64'(owb[k]), 64'd0);
      chk("rst_rd", k, 64'(ord[k]), 64'd0);
      chk("rst_rw", k, 64'(orw[k]), 64'd0);
      chk("rst_ready", k, 64'(ir[k]), 64'd1);
      chk("rst_cnt", k, dut_cnt(k), 64'd0);
    end
    rst = 1'b0;

    // Streaming, one-cycle latency.
    new_src();
    for (int i = 0; i < 4; i++) src.push_back(mk(32'hFFFF0000 + 32'(i), 32'h10 + 32'(i), 1'b1, 1'b0, 5'd5));
    out_ready = 1'b1; src_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stream_wb", 0, 64'(owb[0]), 64'(32'h10 + 32'(i)));
      chk("stream_wb", 1, 64'(owb[1]), 64'(32'h10 + 32'(i)));
      chk("stream_rw", 0, 64'(orw[0]), 64'd1);
    end
    step();
    chk("stream_cnt", 0, dut_cnt(0), 64'd4);
    chk("stream_cnt", 1, dut_cnt(1), 64'd4);
    chk("model_cnt", 0, 64'(mcnt[0]), 64'd4);

    // x0 write suppressed but retired.
    new_src();
    src.push_back(mk(32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 5'd0));
    step();
    chk("x0_valid", 0, 64'(ov[0]), 64'd1);
    chk("x0_rw", 0, 64'(orw[0]), 64'd0);
    chk("x0_wb", 0, 64'(owb[0]), 64'hDEADBEEF);
    step();
    chk("x0_cnt", 0, dut_cnt(0), 64'd5);

    // Back-pressure: A and B held, C waits, then drained in order.
    new_src();
    src.push_back(mk(32'hAAAA0000, 32'h1, 1'b1, 1'b1, 5'd1));
    src.push_back(mk(32'hBBBB0000, 32'h2, 1'b1, 1'b1, 5'd2));
    src.push_back(mk(32'h3, 32'hCCCC0000, 1'b1, 1'b0, 5'd3));
    out_ready = 1'b0;
    step(); step(); step();
    chk("bp_ready", 0, 64'(ir[0]), 64'd0);
    chk("bp_ready", 1, 64'(ir[1]), 64'd0);
    chk("bp_head", 0, 64'(owb[0]), 64'hAAAA0000);
    chk("bp_head", 1, 64'(owb[1]), 64'hAAAA0000);
    out_ready = 1'b1;
    #1;
    chk("bp_comb_ready", 1, 64'(ir[1]), 64'd1);
    chk("bp_reg_ready", 0, 64'(ir[0]), 64'd0);
    step();
    chk("bp_second", 0, 64'(owb[0]), 64'hBBBB0000);
    chk("bp_second", 1, 64'(owb[1]), 64'hBBBB0000);
    step();
    chk("bp_third", 0, 64'(owb[0]), 64'hCCCC0000);
    chk("bp_third", 1, 64'(owb[1]), 64'hCCCC0000);
    step();
    chk("bp_empty", 0, 64'(ov[0]), 64'd0);
    chk("bp_cnt", 0, dut_cnt(0), 64'd8);

    // Flush while full with an offer pending; the offer is dropped.
    new_src();
    for (int i = 0; i < 3; i++) src.push_back(mk(32'h0, 32'h700 + 32'(i), 1'b1, 1'b0, 5'd7));
    out_ready = 1'b0;
    step(); step();
    chk("fl_two", 0, 64'(ir[0]), 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0; src_en = 1'b0;
    chk("fl_valid", 0, 64'(ov[0]), 64'd0);
    chk("fl_ready", 0, 64'(ir[0]), 64'd1);
    step();
    chk("fl_stays_empty", 0, 64'(ov[0]), 64'd0);

    // Flush in ONE: retiring head still counts, fired offer is discarded.
    new_src();
    src.push_back(mk(32'h0, 32'h801, 1'b1, 1'b0, 5'd8));
    src.push_back(mk(32'h0, 32'h802, 1'b1, 1'b0, 5'd8));
    src_en = 1'b1;
    step();
    out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; src_en = 1'b0;
    chk("fl1_valid", 0, 64'(ov[0]), 64'd0);
    chk("fl1_cnt", 0, dut_cnt(0), 64'd9);
    chk("fl1_cnt", 1, dut_cnt(1), 64'd9);
    step();
    chk("fl1_dropped", 0, 64'(ov[0]), 64'd0);

    // Reset mid-operation, then a normal push.
    new_src();
    src.push_back(mk(32'h0, 32'h901, 1'b1, 1'b0, 5'd9));
    out_ready = 1'b0; src_en = 1'b1;
    step();
    src_en = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_valid", 0, 64'(ov[0]), 64'd0);
    chk("mrst_wb", 0, 64'(owb[0]), 64'd0);
    chk("mrst_rd", 0, 64'(ord[0]), 64'd0);
    chk("mrst_cnt", 0, dut_cnt(0), 64'd0);
    new_src();
    src.push_back(mk(32'h0, 32'h55, 1'b1, 1'b0, 5'd3));
    src_en = 1'b1;
    step();
    chk("post_rst_valid", 0, 64'(ov[0]), 64'd1);
    chk("post_rst_wb", 0, 64'(owb[0]), 64'h55);
    chk("post_rst_rd", 0, 64'(ord[0]), 64'd3);

    // Counter wrap on the 4-bit instance.
    rst = 1'b1; src_en = 1'b0;
    step();
    rst = 1'b0;
    new_src();
    for (int i = 0; i < 17; i++) src.push_back(mk(32'(i), 32'(i) + 32'h100, 1'b1, i[0], 5'(i + 1)));
    out_ready = 1'b1; src_en = 1'b1;
    for (int i = 0; i < 19; i++) step();
    chk("wrap_cnt4", 2, dut_cnt(2), 64'd1);
    chk("wrap_cnt32", 0, dut_cnt(0), 64'd17);

    src_en = 1'b0;
    step();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
